imm_ext_pipe: RTL
=================

# imm_ext_pipe

Parametrised, pipelined immediate-extension stage for the decode path of the CPU datapath. It takes an IN_W-bit instruction immediate plus a mode selector and produces an OUT_W-bit operand: sign-extended, zero-extended, upper-placed (LUI) or branch-offset scaled. Results are registered behind a 2-entry skid buffer with valid/ready handshakes on both sides, so decode can stall without losing immediates. A tag travels with each entry so downstream logic can match results to instructions.

## Interface
- IN_W, default 16: immediate input width; must be ≥ 2.
- OUT_W, default 32: extended output width; must satisfy OUT_W ≥ IN_W + SHIFT_B.
- SHIFT_B, default 2: left shift applied in branch mode (word-offset scaling).
- TAG_W, default 5: width of the passthrough tag.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronously discards all buffered entries.
- in_valid  input  1  upstream offers an immediate.
- in_ready  output  1  stage can accept this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  out_data/out_tag hold a valid result.
- out_ready  input  1  downstream consumes this cycle.
- out_data  output  OUT_W  extended immediate.
- out_tag  output  TAG_W  tag of the result on out_data.

## Operation
- Extension is computed combinationally at the input and stored already extended.
  - 00 sign: bits [OUT_W-1:IN_W] = in_imm[IN_W-1], low IN_W bits = in_imm.
  - 01 zero: upper bits 0, low IN_W bits = in_imm.
  - 10 upper: in_imm placed at [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - 11 branch: sign-extend to OUT_W, then shift left by SHIFT_B. Shifted-out MSBs are discarded and the low SHIFT_B bits are 0.
- Storage has two entries: main (drives the outputs) and skid.
- Input handshake: the stage accepts an input when in_valid && in_ready.
- Output handshake: the stage pops an entry when out_valid && out_ready.
- Buffer states, as (main_v, skid_v):
  - EMPTY (0,0): an accept loads main.
  - ONE (1,0):
    - pop and accept: main is replaced by the new input.
    - pop only: go to EMPTY.
    - accept only: the input goes to skid, giving FULL.
  - FULL (1,1): in_ready = 0. On a pop, skid moves to main and the state returns to ONE.
  - (0,1) is unreachable.
- Entries leave in acceptance order. No entry is duplicated or dropped except by flush or rst.
- flush: next cycle both entries are invalid. An input presented in the flush cycle is dropped, even if in_ready was 1. A pop in the flush cycle still counts as consumed.
- rst has priority over flush and over all handshakes.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1, both entries invalid.
- Latency: an input accepted at edge N is visible on out_data at edge N (out_valid high in cycle N+1) when the buffer was empty. Minimum latency is 1 cycle.
- Throughput: one result per cycle while out_ready stays high.
- in_ready is a register output, equal to !skid_v. It has no combinational path from out_ready.
- out_data/out_tag hold steady while out_valid && !out_ready.
- When the buffer is FULL with a pop, in_ready rises the following cycle.
- Reset mid-operation: in the cycle after rst is sampled high, all outputs are at their reset values and buffered data is lost.

## Test plan
- Mode sweep (IN_W=16, OUT_W=32, SHIFT_B=2), out_ready=1:
  - 0x8001 in mode 00 -> 0xFFFF8001.
  - 0x8001 in mode 01 -> 0x00008001.
  - 0x1234 in mode 10 -> 0x12340000.
  - 0xFFFF in mode 11 -> 0xFFFFFFFC.
  - 0x7FFF in mode 11 -> 0x0001FFFC.
  - Each result appears 1 cycle after acceptance, with its tag.
- Streaming: 8 back-to-back inputs with tags 0..7 and out_ready=1 -> 8 consecutive outputs, in order, with no bubbles.
- Backpressure:
  - Hold out_ready=0 and offer tags 1, 2, 3 on consecutive cycles -> tags 1 and 2 accepted, in_ready=0 from the cycle after the second accept, tag 3 held upstream.
  - Release out_ready -> outputs appear in order 1, 2, 3, and out_data stays stable during the stall.
- Flush: with the buffer FULL, assert flush together with in_valid (tag 9) -> next cycle out_valid=0 and in_ready=1, and tag 9 never appears.
- Reset mid-stream: assert rst with the buffer FULL and out_ready=0 -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1. A fresh input afterwards emerges normally.
- Parameter variant IN_W=12, OUT_W=32, SHIFT_B=1: 0x800 in mode 11 -> 0xFFFFF000. 0xABC in mode 10 -> 0xABC00000.

Source files
------------

// File: rtl/imm_ext_if.sv
// Handshake bundle for the immediate-extension stage.
//   in_valid/in_ready/in_imm/in_mode/in_tag : upstream offer of a raw immediate
//   out_valid/out_ready/out_data/out_tag    : downstream extended result
// master = upstream/downstream environment, slave = the extension stage.
interface imm_ext_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_imm, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_imm, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extension with a 2-entry skid buffer.
// Extends an IN_W-bit immediate to OUT_W bits (sign / zero / upper / branch-scaled)
// at the input and stores it, with its tag, in a main/skid register pair.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (highest priority)
//   flush : discards all buffered entries and any input offered this cycle
//   bus   : imm_ext_if.slave handshake bundle (in_* upstream, out_* downstream)
module imm_ext_pipe #(
   parameter int unsigned IN_W    = 16,
   parameter int unsigned OUT_W   = 32,
   parameter int unsigned SHIFT_B = 2,
   parameter int unsigned TAG_W   = 5
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   imm_ext_if.slave  bus
);

   localparam int unsigned UPPER_SH = OUT_W - IN_W;

   // Buffer occupancy encoded as {main_v, skid_v}; (0,1) is never entered
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   localparam logic [1:0] MODE_SIGN   = 2'b00;
   localparam logic [1:0] MODE_ZERO   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   logic [1:0]       state_q;
   logic [1:0]       state_nxt;
   logic             in_ready_q;
   logic [OUT_W-1:0] main_data_q;
   logic [TAG_W-1:0] main_tag_q;
   logic [OUT_W-1:0] skid_data_q;
   logic [TAG_W-1:0] skid_tag_q;

   logic [OUT_W-1:0] sext_c;
   logic [OUT_W-1:0] ext_c;
   logic             accept_c;
   logic             pop_c;
   logic             load_main_in_c;
   logic             load_main_skid_c;
   logic             load_skid_c;

   // Extension of the incoming immediate
   always_comb begin
      sext_c = OUT_W'($signed(bus.in_imm));
      ext_c  = sext_c;
      case (bus.in_mode)
         MODE_SIGN:   ext_c = sext_c;
         MODE_ZERO:   ext_c = OUT_W'(bus.in_imm);
         MODE_UPPER:  ext_c = OUT_W'(bus.in_imm) << UPPER_SH;
         MODE_BRANCH: ext_c = sext_c << SHIFT_B;
         default:     ext_c = sext_c;
      endcase
   end

   // An input offered during flush is dropped even when in_ready is high
   assign accept_c = bus.in_valid && in_ready_q && !flush;
   assign pop_c    = state_q[1] && bus.out_ready;

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= ~state_nxt[0];
      end
   end

   // Next occupancy and data-path load controls
   always_comb begin
      state_nxt        = state_q;
      load_main_in_c   = 1'b0;
      load_main_skid_c = 1'b0;
      load_skid_c      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept_c) begin
               load_main_in_c = 1'b1;
               state_nxt      = ST_ONE;
            end
         end
         ST_ONE: begin
            if (pop_c && accept_c) begin
               load_main_in_c = 1'b1;
            end else if (pop_c) begin
               state_nxt = ST_EMPTY;
            end else if (accept_c) begin
               load_skid_c = 1'b1;
               state_nxt   = ST_FULL;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a pop can happen
            if (pop_c) begin
               load_main_skid_c = 1'b1;
               state_nxt        = ST_ONE;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_nxt        = ST_EMPTY;
         load_main_in_c   = 1'b0;
         load_main_skid_c = 1'b0;
         load_skid_c      = 1'b0;
      end
   end

   // Main and skid payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data_q <= '0;
         main_tag_q  <= '0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
      end else begin
         if (load_main_in_c) begin
            main_data_q <= ext_c;
            main_tag_q  <= bus.in_tag;
         end else if (load_main_skid_c) begin
            main_data_q <= skid_data_q;
            main_tag_q  <= skid_tag_q;
         end
         if (load_skid_c) begin
            skid_data_q <= ext_c;
            skid_tag_q  <= bus.in_tag;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = state_q[1];
   assign bus.out_data  = main_data_q;
   assign bus.out_tag   = main_tag_q;

endmodule
